// File: rtl/mem_slot_arbiter_if.sv
// Memory slot arbiter bus: requester handshakes, memory port strobes and owner flags.
`default_nettype none

interface mem_slot_arbiter_if #(
    parameter int ADDR_W = 22
);
    logic              clk8_en_p;
    logic              video_req;
    logic [ADDR_W-1:0] video_addr;
    logic              sound_req;
    logic [ADDR_W-1:0] sound_addr;
    logic              dsk_int_req;
    logic [ADDR_W-1:0] dsk_int_addr;
    logic              dsk_ext_req;
    logic [ADDR_W-1:0] dsk_ext_addr;
    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_uds_n;
    logic              cpu_lds_n;
    logic [ADDR_W-1:0] cpu_addr;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_oe;
    logic              mem_we;
    logic              mem_ube;
    logic              mem_lbe;
    logic              mem_latch;
    logic              video_bus_ctl;
    logic              cpu_bus_ctl;
    logic              video_ack;
    logic              sound_ack;
    logic              dsk_int_ack;
    logic              dsk_ext_ack;
    logic              cpu_ack;

    modport master (
        output clk8_en_p, video_req, video_addr, sound_req, sound_addr,
               dsk_int_req, dsk_int_addr, dsk_ext_req, dsk_ext_addr,
               cpu_req, cpu_we, cpu_uds_n, cpu_lds_n, cpu_addr,
        input  mem_addr, mem_oe, mem_we, mem_ube, mem_lbe, mem_latch,
               video_bus_ctl, cpu_bus_ctl,
               video_ack, sound_ack, dsk_int_ack, dsk_ext_ack, cpu_ack
    );

    modport slave (
        input  clk8_en_p, video_req, video_addr, sound_req, sound_addr,
               dsk_int_req, dsk_int_addr, dsk_ext_req, dsk_ext_addr,
               cpu_req, cpu_we, cpu_uds_n, cpu_lds_n, cpu_addr,
        output mem_addr, mem_oe, mem_we, mem_ube, mem_lbe, mem_latch,
               video_bus_ctl, cpu_bus_ctl,
               video_ack, sound_ack, dsk_int_ack, dsk_ext_ack, cpu_ack
    );
endinterface

`default_nettype wire

// File: rtl/mem_slot_arbiter.sv
// ============================================================================
// Module   : mem_slot_arbiter
// Brief    : Fixed 4-phase memory slot arbiter for video, sound, floppy, CPU.
//            Optional external-floppy owner enabled by MEM_ARB_DISK_EXT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_slot_arbiter #(
    parameter int ADDR_W         = 22,
    parameter int CPU_STARVE_MAX = 3
) (
    input  wire logic         clk32,
    input  wire logic         reset,
    mem_slot_arbiter_if.slave bus
);

    localparam int STARVE_W = (CPU_STARVE_MAX < 1) ? 1 : $clog2(CPU_STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(CPU_STARVE_MAX);

    localparam int C_ACK_VIDEO   = 0;
    localparam int C_ACK_SOUND   = 1;
    localparam int C_ACK_DSK_INT = 2;
    localparam int C_ACK_DSK_EXT = 3;
    localparam int C_ACK_CPU     = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_VIDEO   = 3'd1,
        S_SOUND   = 3'd2,
        S_DSK_INT = 3'd3,
        S_DSK_EXT = 3'd4,
        S_CPU     = 3'd5
    } owner_t;

    owner_t              r_owner;
    logic [1:0]          r_phase;
    logic [STARVE_W-1:0] r_starve;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_oe;
    logic                r_mem_we;
    logic                r_mem_ube;
    logic                r_mem_lbe;
    logic                r_mem_latch;
    logic                r_video_bus_ctl;
    logic                r_cpu_bus_ctl;
    logic [4:0]          r_ack;

    owner_t              w_next_owner;
    logic [ADDR_W-1:0]   w_next_addr;
    logic                w_next_write;
    logic                w_next_ube;
    logic                w_next_lbe;
    logic                w_starved;
    logic                w_dsk_ext_req;

`ifdef MEM_ARB_DISK_EXT_EN
    assign w_dsk_ext_req    = bus.dsk_ext_req;
    assign bus.dsk_ext_ack  = r_ack[C_ACK_DSK_EXT];
`else
    logic w_unused_dsk_ext;
    assign w_dsk_ext_req    = 1'b0;
    assign bus.dsk_ext_ack  = 1'b0;
    assign w_unused_dsk_ext = ^{bus.dsk_ext_req, bus.dsk_ext_addr, r_ack[C_ACK_DSK_EXT]};
`endif

    assign w_starved = (r_starve == C_STARVE_MAX);

    // A starved CPU slots in directly below video; otherwise it is last.
    always_comb begin
        w_next_owner = S_IDLE;
        if (bus.video_req)                  w_next_owner = S_VIDEO;
        else if (bus.cpu_req && w_starved)  w_next_owner = S_CPU;
        else if (bus.sound_req)             w_next_owner = S_SOUND;
        else if (bus.dsk_int_req)           w_next_owner = S_DSK_INT;
        else if (w_dsk_ext_req)             w_next_owner = S_DSK_EXT;
        else if (bus.cpu_req)               w_next_owner = S_CPU;
    end

    always_comb begin
        w_next_addr  = r_mem_addr;
        w_next_write = 1'b0;
        w_next_ube   = 1'b1;
        w_next_lbe   = 1'b1;
        case (w_next_owner)
            S_VIDEO:   w_next_addr = bus.video_addr;
            S_SOUND:   w_next_addr = bus.sound_addr;
            S_DSK_INT: w_next_addr = bus.dsk_int_addr;
            S_DSK_EXT: w_next_addr = bus.dsk_ext_addr;
            S_CPU: begin
                w_next_addr  = bus.cpu_addr;
                w_next_write = bus.cpu_we;
                w_next_ube   = ~bus.cpu_uds_n;
                w_next_lbe   = ~bus.cpu_lds_n;
            end
            default: begin
                w_next_ube = 1'b0;
                w_next_lbe = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            r_phase         <= 2'd0;
            r_owner         <= S_IDLE;
            r_starve        <= '0;
            r_mem_addr      <= '0;
            r_mem_oe        <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_ube       <= 1'b0;
            r_mem_lbe       <= 1'b0;
            r_mem_latch     <= 1'b0;
            r_video_bus_ctl <= 1'b0;
            r_cpu_bus_ctl   <= 1'b0;
            r_ack           <= '0;
        end else begin
            r_mem_latch <= 1'b0;
            r_ack       <= '0;
            if (bus.clk8_en_p) begin
                r_phase <= r_phase + 2'd1;
                if (r_phase == 2'd3) begin
                    r_owner         <= w_next_owner;
                    r_video_bus_ctl <= (w_next_owner == S_VIDEO);
                    r_cpu_bus_ctl   <= (w_next_owner == S_CPU);
                    r_mem_addr      <= w_next_addr;
                    r_mem_oe        <= (w_next_owner != S_IDLE) && !w_next_write;
                    r_mem_we        <= w_next_write;
                    r_mem_ube       <= w_next_ube;
                    r_mem_lbe       <= w_next_lbe;
                    if ((w_next_owner == S_CPU) || !bus.cpu_req)
                        r_starve <= '0;
                    else if (!w_starved)
                        r_starve <= r_starve + STARVE_W'(1);
                end else if (r_phase == 2'd2) begin
                    // Leaving phase 2 completes the access; a write ends here too.
                    r_mem_we    <= 1'b0;
                    r_mem_latch <= r_mem_oe;
                    case (r_owner)
                        S_VIDEO:   r_ack[C_ACK_VIDEO]   <= 1'b1;
                        S_SOUND:   r_ack[C_ACK_SOUND]   <= 1'b1;
                        S_DSK_INT: r_ack[C_ACK_DSK_INT] <= 1'b1;
                        S_DSK_EXT: r_ack[C_ACK_DSK_EXT] <= 1'b1;
                        S_CPU:     r_ack[C_ACK_CPU]     <= 1'b1;
                        default:   ;
                    endcase
                end
            end
        end
    end

    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_oe        = r_mem_oe;
    assign bus.mem_we        = r_mem_we;
    assign bus.mem_ube       = r_mem_ube;
    assign bus.mem_lbe       = r_mem_lbe;
    assign bus.mem_latch     = r_mem_latch;
    assign bus.video_bus_ctl = r_video_bus_ctl;
    assign bus.cpu_bus_ctl   = r_cpu_bus_ctl;
    assign bus.video_ack     = r_ack[C_ACK_VIDEO];
    assign bus.sound_ack     = r_ack[C_ACK_SOUND];
    assign bus.dsk_int_ack   = r_ack[C_ACK_DSK_INT];
    assign bus.cpu_ack       = r_ack[C_ACK_CPU];

endmodule

`default_nettype wire
